// File: rtl/video_crop_decim_if.sv
// Pixel stream bundle: frame sync, pixel valid, pixel data and line/frame
// end markers. The master drives the stream and the slave consumes it.
interface video_crop_decim_if #(
    parameter int WIDTH = 24
) ();
    logic             vs;
    logic             de;
    logic [WIDTH-1:0] data;
    logic             eol;
    logic             eof;

    modport master (output vs, de, data, eol, eof);
    modport slave  (input  vs, de, data, eol, eof);
endinterface

// File: rtl/video_crop_decim.sv
// Crop-and-decimate stage: keeps pixels inside a frame-latched window,
// optionally every 2^n-th column/row, and tags line/frame ends.
module video_crop_decim #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3,
    parameter int X_WIDTH    = 12,
    parameter int Y_WIDTH    = 12,
    parameter int DEC_BITS   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [X_WIDTH-1:0]  cfg_start_x,
    input  logic [Y_WIDTH-1:0]  cfg_start_y,
    input  logic [X_WIDTH-1:0]  cfg_end_x,
    input  logic [Y_WIDTH-1:0]  cfg_end_y,
    input  logic [DEC_BITS-1:0] cfg_dec_x,
    input  logic [DEC_BITS-1:0] cfg_dec_y,
    video_crop_decim_if.slave   pix_in,
    video_crop_decim_if.master  pix_out,
    output logic                active_o,
    output logic [X_WIDTH-1:0]  out_w_o,
    output logic [Y_WIDTH-1:0]  out_h_o,
    output logic                cfg_err_o
);
    localparam int PIX_W = DATA_WIDTH * CHANNELS;

    typedef enum logic [1:0] {IDLE, FRAME, DONE} state_t;

    function automatic logic [X_WIDTH-1:0] sat_inc_x(input logic [X_WIDTH-1:0] v);
        return (&v) ? v : v + X_WIDTH'(1);
    endfunction

    function automatic logic [Y_WIDTH-1:0] sat_inc_y(input logic [Y_WIDTH-1:0] v);
        return (&v) ? v : v + Y_WIDTH'(1);
    endfunction

    // True when the offset from the window origin lands on the decimation grid.
    function automatic logic phase_ok_x(input logic [X_WIDTH-1:0] off,
                                        input logic [DEC_BITS-1:0] dec);
        logic [X_WIDTH-1:0] mask;
        mask = ~({X_WIDTH{1'b1}} << dec);
        return (off & mask) == '0;
    endfunction

    function automatic logic phase_ok_y(input logic [Y_WIDTH-1:0] off,
                                        input logic [DEC_BITS-1:0] dec);
        logic [Y_WIDTH-1:0] mask;
        mask = ~({Y_WIDTH{1'b1}} << dec);
        return (off & mask) == '0;
    endfunction

    state_t              state, state_nxt;
    logic                vs_d, de_d, calc_p1;
    logic [X_WIDTH-1:0]  sh_start_x, sh_end_x, x_cnt;
    logic [Y_WIDTH-1:0]  sh_start_y, sh_end_y, y_cnt;
    logic [DEC_BITS-1:0] sh_dec_x, sh_dec_y;
    logic                frame_en;
    logic                unused_in;

    // eol/eof on the input side carry no meaning for this stage
    assign unused_in = ^{pix_in.eol, pix_in.eof};

    wire vs_rise = pix_in.vs & ~vs_d;
    wire de_fall = de_d & ~pix_in.de;

    // Output geometry derived from the shadowed window
    wire [X_WIDTH-1:0] win_w  = sh_end_x - sh_start_x;
    wire [Y_WIDTH-1:0] win_h  = sh_end_y - sh_start_y;
    wire [X_WIDTH-1:0] geo_w  = ((win_w - X_WIDTH'(1)) >> sh_dec_x) + X_WIDTH'(1);
    wire [Y_WIDTH-1:0] geo_h  = ((win_h - Y_WIDTH'(1)) >> sh_dec_y) + Y_WIDTH'(1);
    wire [X_WIDTH-1:0] last_x = sh_start_x + ((geo_w - X_WIDTH'(1)) << sh_dec_x);
    wire [Y_WIDTH-1:0] last_y = sh_start_y + ((geo_h - Y_WIDTH'(1)) << sh_dec_y);
    wire               err    = (sh_end_x <= sh_start_x) | (sh_end_y <= sh_start_y);

    // Pixel keep decision and markers for the pixel sampled this cycle
    wire kept = frame_en & pix_in.de & ~vs_rise
              & (x_cnt >= sh_start_x) & (x_cnt < sh_end_x)
              & (y_cnt >= sh_start_y) & (y_cnt < sh_end_y)
              & phase_ok_x(x_cnt - sh_start_x, sh_dec_x)
              & phase_ok_y(y_cnt - sh_start_y, sh_dec_y);
    wire eol_now = kept & (x_cnt == last_x);
    wire eof_now = eol_now & (y_cnt == last_y);

    // Edge detectors; a de coincident with the latch does not count as a line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d    <= 1'b0;
            de_d    <= 1'b0;
            calc_p1 <= 1'b0;
        end else begin
            vs_d    <= pix_in.vs;
            de_d    <= vs_rise ? 1'b0 : pix_in.de;
            calc_p1 <= vs_rise;
        end
    end

    // Shadow configuration, captured only at the frame latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_start_x <= '0;
            sh_end_x   <= '0;
            sh_start_y <= '0;
            sh_end_y   <= '0;
            sh_dec_x   <= '0;
            sh_dec_y   <= '0;
        end else if (vs_rise) begin
            sh_start_x <= cfg_start_x;
            sh_end_x   <= cfg_end_x;
            sh_start_y <= cfg_start_y;
            sh_end_y   <= cfg_end_y;
            sh_dec_x   <= cfg_dec_x;
            sh_dec_y   <= cfg_dec_y;
        end
    end

    // Saturating column/row counters of the incoming raster
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (vs_rise) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (pix_in.de) begin
            x_cnt <= sat_inc_x(x_cnt);
        end else if (de_fall) begin
            x_cnt <= '0;
            y_cnt <= sat_inc_y(y_cnt);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: any latch restarts the frame, the last kept pixel ends it
    always_comb begin
        state_nxt = state;
        if (vs_rise)                       state_nxt = FRAME;
        else if (state == FRAME && eof_now) state_nxt = DONE;
    end

    // Pixels are only forwarded while a valid frame is in progress
    always_comb begin
        frame_en = 1'b0;
        if (state == FRAME && !err) frame_en = 1'b1;
    end

    // Geometry/error report, registered the cycle after the shadows load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_w_o   <= '0;
            out_h_o   <= '0;
            cfg_err_o <= 1'b0;
        end else if (calc_p1) begin
            out_w_o   <= err ? '0 : geo_w;
            out_h_o   <= err ? '0 : geo_h;
            cfg_err_o <= err;
        end
    end

    // Output pixel register; data holds its last kept value between pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_out.vs   <= 1'b0;
            pix_out.de   <= 1'b0;
            pix_out.eol  <= 1'b0;
            pix_out.eof  <= 1'b0;
            pix_out.data <= '0;
        end else begin
            pix_out.vs  <= pix_in.vs;
            pix_out.de  <= kept;
            pix_out.eol <= eol_now;
            pix_out.eof <= eof_now;
            if (kept) pix_out.data <= pix_in.data[PIX_W-1:0];
        end
    end

    // Active flag: set by the latch, dropped the cycle after eof is shown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           active_o <= 1'b0;
        else if (vs_rise)     active_o <= 1'b1;
        else if (pix_out.eof) active_o <= 1'b0;
    end
endmodule

// File: tb/tb_video_crop_decim.sv
// Directed bench for video_crop_decim: drives small frames and checks every
// output cycle against hand-derived keep masks and marker positions.
module tb_video_crop_decim;
    localparam int PW = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] cfg_start_x, cfg_start_y, cfg_end_x, cfg_end_y;
    logic [1:0]  cfg_dec_x, cfg_dec_y;
    logic        active_o, cfg_err_o;
    logic [11:0] out_w_o, out_h_o;

    int tests = 0;
    int fails = 0;
    logic [PW-1:0] exp_last = '0;

    video_crop_decim_if #(.WIDTH(PW)) in_if ();
    video_crop_decim_if #(.WIDTH(PW)) out_if ();

    video_crop_decim dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start_x(cfg_start_x), .cfg_start_y(cfg_start_y),
        .cfg_end_x(cfg_end_x), .cfg_end_y(cfg_end_y),
        .cfg_dec_x(cfg_dec_x), .cfg_dec_y(cfg_dec_y),
        .pix_in(in_if), .pix_out(out_if),
        .active_o(active_o), .out_w_o(out_w_o), .out_h_o(out_h_o),
        .cfg_err_o(cfg_err_o)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] pix(input int x, input int y);
        return {8'h5A, 8'(y), 8'(x)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one input sample, let it be clocked, then settle past the edge.
    task automatic step(input logic vs, input logic de, input logic [PW-1:0] d);
        in_if.vs   = vs;
        in_if.de   = de;
        in_if.data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int sx, input int sy, input int ex, input int ey,
                           input int dx, input int dy);
        cfg_start_x = 12'(sx); cfg_start_y = 12'(sy);
        cfg_end_x   = 12'(ex); cfg_end_y   = 12'(ey);
        cfg_dec_x   = 2'(dx);  cfg_dec_y   = 2'(dy);
    endtask

    task automatic vs_pulse(input int ew, input int eh, input logic eerr);
        step(1'b1, 1'b0, '0);
        check("vs_o_high", 64'(out_if.vs), 64'(1));
        check("active_rise", 64'(active_o), 64'(1));
        step(1'b0, 1'b0, '0);
        check("vs_o_low", 64'(out_if.vs), 64'(0));
        check("geometry", {out_w_o, out_h_o, 7'd0, cfg_err_o}, {12'(ew), 12'(eh), 7'd0, eerr});
    endtask

    // Drives a w x h raster with a two-cycle blanking gap after each line.
    task automatic run_frame(input int w, input int h, input logic [15:0] xm,
                             input logic [15:0] ym, input int lx, input int ly,
                             input bit expect_end, input int chg_row,
                             input logic [11:0] new_sx);
        logic k, el, ef;
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                step(1'b0, 1'b1, pix(x, y));
                k  = xm[x] & ym[y];
                el = k && (x == lx);
                ef = el && (y == ly);
                if (k) exp_last = pix(x, y);
                check("pixel", {out_if.de, out_if.eol, out_if.eof, out_if.data},
                      {k, el, ef, exp_last});
            end
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 1'b0, '0);
                check("blank", {out_if.de, out_if.eol, out_if.eof, out_if.data},
                      {3'b000, exp_last});
                if (y == h - 1 && g == 0)
                    check("active_end", 64'(active_o), 64'(!expect_end));
            end
            if (y == chg_row) cfg_start_x = new_sx;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_if.vs = 1'b0; in_if.de = 1'b0; in_if.data = '0;
        in_if.eol = 1'b0; in_if.eof = 1'b0;
        set_cfg(0, 0, 8, 4, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs",
              {out_if.vs, out_if.de, out_if.eol, out_if.eof, active_o, cfg_err_o, out_if.data},
              64'(0));
        check("reset_geometry", {out_w_o, out_h_o}, 64'(0));
        rst_n = 1'b1;

        // de before the first sync is ignored
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, pix(i, 0));
            check("idle_de", 64'(out_if.de), 64'(0));
        end
        step(1'b0, 1'b0, '0);

        // Full window, no decimation
        vs_pulse(8, 4, 1'b0);
        run_frame(8, 4, 16'h00FF, 16'h000F, 7, 3, 1'b1, -1, 12'd0);

        // Crop (2,1)-(11,7) with 2x2 decimation
        set_cfg(2, 1, 11, 7, 1, 1);
        vs_pulse(5, 3, 1'b0);
        run_frame(16, 8, 16'b0000_0101_0101_0100, 16'b0010_1010, 10, 5, 1'b1, -1, 12'd0);

        // Empty window in x flags an error and forwards nothing
        set_cfg(5, 0, 5, 4, 0, 0);
        vs_pulse(0, 0, 1'b1);
        run_frame(8, 4, 16'h0000, 16'h0000, 99, 99, 1'b0, -1, 12'd0);

        // Valid config clears the error; start_x changes mid-frame
        set_cfg(0, 0, 8, 4, 0, 0);
        vs_pulse(8, 4, 1'b0);
        run_frame(8, 4, 16'h00FF, 16'h000F, 7, 3, 1'b1, 1, 12'd4);
        vs_pulse(4, 4, 1'b0);
        run_frame(8, 4, 16'h00F0, 16'h000F, 7, 3, 1'b1, -1, 12'd0);

        // Frame aborted after two rows, then a complete frame
        set_cfg(0, 0, 8, 4, 0, 0);
        vs_pulse(8, 4, 1'b0);
        run_frame(8, 2, 16'h00FF, 16'h000F, 7, 3, 1'b0, -1, 12'd0);
        vs_pulse(8, 4, 1'b0);
        run_frame(8, 4, 16'h00FF, 16'h000F, 7, 3, 1'b1, -1, 12'd0);

        // Asynchronous reset in the middle of a line
        vs_pulse(8, 4, 1'b0);
        for (int x = 0; x < 3; x++) begin
            step(1'b0, 1'b1, pix(x, 0));
            exp_last = pix(x, 0);
            check("pre_reset_pixel", {out_if.de, out_if.data}, {1'b1, exp_last});
        end
        rst_n = 1'b0;
        #1;
        check("async_reset",
              {out_if.vs, out_if.de, out_if.eol, out_if.eof, active_o, cfg_err_o, out_if.data},
              64'(0));
        check("async_reset_geo", {out_w_o, out_h_o}, 64'(0));
        #2;
        rst_n = 1'b1;
        exp_last = '0;
        for (int x = 3; x < 8; x++) begin
            step(1'b0, 1'b1, pix(x, 0));
            check("post_reset_idle", {out_if.de, out_if.data}, {1'b0, exp_last});
        end
        step(1'b0, 1'b0, '0);
        vs_pulse(8, 4, 1'b0);
        run_frame(8, 4, 16'h00FF, 16'h000F, 7, 3, 1'b1, -1, 12'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/video_crop_decim.md
# video_crop_decim

Parametrised crop-and-decimate stage for the video-process path. It sits between the video input and the scaler FIFO. It takes a raw vs/de/data pixel stream and passes only pixels inside a runtime-programmable window. Within that window it can keep every 2^n-th pixel and line for power-of-two pre-decimation. Compared with the fixed-channel crop it replaces, it adds:
- generic width and channel count;
- frame-synchronous shadowed configuration;
- decimation;
- line and frame markers;
- output geometry reporting;
- configuration error detection.

## Interface
- DATA_WIDTH, 8, bits per colour channel
- CHANNELS, 3, channels per pixel
- X_WIDTH, 12, width of column counters and coordinates
- Y_WIDTH, 12, width of row counters and coordinates
- DEC_BITS, 2, width of the log2 decimation fields; maximum factor is 2^(2^DEC_BITS-1)
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- cfg_start_x  in  X_WIDTH  first kept column (inclusive)
- cfg_start_y  in  Y_WIDTH  first kept row (inclusive)
- cfg_end_x  in  X_WIDTH  column end (exclusive)
- cfg_end_y  in  Y_WIDTH  row end (exclusive)
- cfg_dec_x  in  DEC_BITS  log2 horizontal decimation
- cfg_dec_y  in  DEC_BITS  log2 vertical decimation
- vs_i  in  1  frame sync, active high
- de_i  in  1  pixel valid
- data_i  in  DATA_WIDTH*CHANNELS  pixel
- vs_o  out  1  vs_i delayed 1 cycle
- de_o  out  1  kept pixel valid
- data_o  out  DATA_WIDTH*CHANNELS  kept pixel
- eol_o  out  1  with de_o: last kept pixel of the line
- eof_o  out  1  with de_o: last kept pixel of the frame
- active_o  out  1  high from the frame latch until eof_o or the next vs
- out_w_o  out  X_WIDTH  kept pixels per line for the current frame
- out_h_o  out  Y_WIDTH  kept lines for the current frame
- cfg_err_o  out  1  current frame's configuration is invalid

## Operation
- **States:** IDLE, FRAME, DONE.
- **Reset:** state = IDLE; every output = 0; counters = 0.
- **Frame latch.** A vs_i rising edge, in any state, does all of the following:
  - copies every cfg_* input into shadow registers;
  - clears x_cnt and y_cnt;
  - moves the state machine to FRAME.
- **Shadowed config:** cfg_* inputs are sampled only at the frame latch; changes mid-frame are ignored.
- **Derived values,** computed in the cycle after the latch:
  - w = end_x - start_x;
  - h = end_y - start_y;
  - out_w = ((w - 1) >> dec_x) + 1;
  - out_h = ((h - 1) >> dec_y) + 1;
  - last_x = start_x + ((out_w - 1) << dec_x);
  - last_y = start_y + ((out_h - 1) << dec_y).
- **Invalid config:** if end_x <= start_x or end_y <= start_y, then cfg_err_o = 1, out_w_o = 0, out_h_o = 0, and no de_o is issued for the frame.
- **Column counter:** x_cnt increments on each de_i cycle, saturates at all-ones, and clears on the de_i falling edge.
- **Row counter:** y_cnt increments on each de_i falling edge and saturates.
- **Keep rule** (applies in FRAME with no error). A pixel is kept when all of these hold:
  - start_x <= x_cnt < end_x;
  - start_y <= y_cnt < end_y;
  - (x_cnt - start_x) low dec_x bits are 0;
  - (y_cnt - start_y) low dec_y bits are 0.
- **Markers:**
  - eol_o = kept and x_cnt == last_x;
  - eof_o = eol_o and y_cnt == last_y.
- **Frame end:** after eof_o the state moves to DONE and active_o drops. Further de_i is ignored until the next vs_i rising edge.
- **Before first sync:** de_i in IDLE is ignored.
- **Mid-frame vs:** a vs_i rising edge mid-frame aborts the frame and starts a new one; no eof_o is issued for the aborted frame.
- **Truncated input:** if the input frame is shorter than the window, the block stays in FRAME with no eof_o until the next vs.
- **Overlapping vs and de:** de_i coincident with the vs_i rising edge is dropped, and the counters start from 0 on the next de_i.
- **Decimation of 1:** dec = 0 is pass-through within the window.

## Timing
- de_o, data_o, eol_o, eof_o and vs_o are all registered, with latency exactly 1 cycle from the de_i / vs_i sample.
- data_o holds its last kept value when de_o = 0.
- out_w_o, out_h_o and cfg_err_o are valid 2 cycles after the vs_i rising edge and stable until the next latch.
- active_o rises 1 cycle after the vs_i rising edge and falls in the cycle after eof_o.
- No backpressure: the downstream stage must accept one pixel per cycle.
- Asynchronous reset mid-frame clears all outputs immediately; the block then waits in IDLE for a vs_i rising edge.

## Test plan
- **Full window:** 8x4 frame, window (0,0)-(8,4), dec 0/0 -> 32 de_o one cycle after de_i, data identical, eol_o on x=7, eof_o on (7,3), out_w_o = 8, out_h_o = 4.
- **Crop plus decimation:** 16x8 frame, window (2,1)-(11,7), dec_x = 1, dec_y = 1 -> columns 2,4,6,8,10 kept on rows 1,3,5; out_w_o = 5, out_h_o = 3; eof_o at (10,5).
- **Invalid config:** window start_x = 5, end_x = 5 -> cfg_err_o = 1, zero de_o, active_o high until the next vs; a valid config latched on the next vs clears cfg_err_o.
- **Shadowing:** change cfg_start_x from 0 to 4 mid-frame -> the current frame still keeps x = 0; the next frame starts at x = 4.
- **Mid-frame vs:** vs_i pulse after row 1 of 4 -> no eof_o; counters restart and the new frame completes normally with eof_o.
- **Reset mid-frame:** assert rst_n low during de -> all outputs 0 in the same cycle; de_i after release and before a vs is ignored (IDLE).
